board_input_debouncer: RTL and testbench
========================================

# board_input_debouncer

Conditions the asynchronous board switches and push-buttons before they reach the CPU and the display-select logic. Each raw input is synchronized into the core clock domain and debounced. The block then produces a clean level plus single-cycle rise and fall pulses. It is the input-side counterpart of the LED and seven-segment output path: outputs leave the core through the display drivers, and switch/button inputs enter the core through this block.

## Interface
Parameters:
- WIDTH, 8: number of independent input channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required before a change is accepted. Must be ≥ 1.

Ports:
- clk_i  in  1  core clock; the only clock.
- rst_i  in  1  synchronous, active-low reset.
- raw_i  in  WIDTH  asynchronous switch/button inputs.
- level_o  out  WIDTH  debounced level per channel.
- rise_o  out  WIDTH  one-cycle pulse when level_o goes 0→1.
- fall_o  out  WIDTH  one-cycle pulse when level_o goes 1→0.
- change_o  out  1  OR-reduction of (rise_o | fall_o).

## Operation
- Channels are fully independent and identical. There is no cross-channel interaction except change_o.
- Per channel, a 2-flop synchronizer feeds sync_q. A 2-state FSM (STABLE, PENDING) and a counter cnt track sync_q against level_o.
  - STABLE: if sync_q == level_o, stay in STABLE with cnt = 0. If sync_q != level_o and DEBOUNCE_CYCLES == 1, flip level_o and stay in STABLE. Otherwise go to PENDING with cnt = 1.
  - PENDING: if sync_q == level_o (glitch), return to STABLE with cnt = 0 and no output change. If sync_q != level_o and cnt == DEBOUNCE_CYCLES-1, flip level_o, go to STABLE, cnt = 0. Otherwise cnt += 1.
- cnt width is $clog2(DEBOUNCE_CYCLES+1). cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- rise_o and fall_o are registered. Each is asserted for exactly the one cycle after the edge on which level_o flips, so it is coincident with the first cycle of the new level_o value. rise_o and fall_o are never both high on one channel.
- A bounce that returns to the accepted level before DEBOUNCE_CYCLES consecutive samples produces no pulse and no level change. The next disagreement restarts counting from 1.

## Timing
- Reset (rst_i low at a clk_i edge) clears the synchronizer flops, level_o, rise_o, fall_o, change_o and cnt to 0, and sets the FSM to STABLE. Reset takes priority over everything, including mid-PENDING. Counting restarts from scratch after reset.
- Latency: raw_i changes and is stable before edge k. sync_q shows the new value after edge k+1. The first disagreeing sample is taken at edge k+2. level_o and the pulse update at edge k+1+DEBOUNCE_CYCLES.
- A raw_i held at 1 through reset counts as a rising change after release. rise_o fires DEBOUNCE_CYCLES+2 edges after the first edge with rst_i high.
- Minimum spacing between accepted changes on one channel is DEBOUNCE_CYCLES cycles. Pulses on one channel are therefore never back-to-back unless DEBOUNCE_CYCLES == 1.
- change_o is a registered OR. It is aligned with rise_o/fall_o in the same cycle.

## Structure
- Shared package board_io_pkg holds:
  - the FSM enum (DB_STABLE, DB_PENDING);
  - the synchronizer depth constant SYNC_STAGES = 2;
  - the board default DEBOUNCE_CYCLES for a 100 MHz clock (10 ms).
- Sub-module debounce_channel holds the synchronizer, FSM, counter and edge registers for one bit. The top instantiates it WIDTH times in a generate loop and builds change_o.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and WIDTH = 8.
- Reset: rst_i low for 3 edges with raw_i = 8'hFF → level_o, rise_o, fall_o = 0 and change_o = 0 during reset. After release, level_o = 8'hFF and rise_o = 8'hFF for one cycle, 6 edges after the first edge with rst_i high.
- Clean press: raw_i[0] goes 0→1 before edge k → level_o[0] = 1 at edge k+5. rise_o[0] and change_o are high for exactly one cycle and fall_o[0] stays 0.
- Bounce rejection: raw_i[3] pulses high for 3 cycles then returns low → level_o[3], rise_o and fall_o stay 0 throughout.
- Bounce then settle: raw_i[3] is high 2 cycles, low 1 cycle, then high steadily → exactly one rise_o[3] pulse, 5 edges after the final 0→1 transition edge.
- Independent channels: raw_i[1] rises and raw_i[6] falls (from an accepted 1) on the same edge → rise_o[1] and fall_o[6] pulse in the same cycle, and change_o is a single one-cycle pulse.
- Reset mid-PENDING: raw_i[2] goes 0→1, then rst_i is low for 1 edge after 2 disagreeing samples → no pulse before reset. After release, rise_o[2] fires at the full post-reset latency of 6 edges.

Source files
------------

// File: rtl/board_io_pkg.sv
// ---------------------------------------------------------------------------
// board_io_pkg
//
// Purpose:
//   Shared definitions for the board input-conditioning path. Holds the
//   per-channel debounce FSM encoding, the synchronizer depth, and the
//   default debounce length for the board's 100 MHz core clock.
//
// Contents:
//   db_state_e             - debounce FSM states (DB_STABLE, DB_PENDING)
//   SYNC_STAGES            - number of flops in each input synchronizer
//   BOARD_CLOCK_HZ         - board core clock frequency
//   BOARD_DEBOUNCE_MS      - settle time accepted as a real switch change
//   BOARD_DEBOUNCE_CYCLES  - settle time expressed in core clock cycles
// ---------------------------------------------------------------------------
package board_io_pkg;

  // STABLE: the synchronized input agrees with the accepted level.
  // PENDING: the input disagrees and is being timed before acceptance.
  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  // Two flops give a metastability-resolved copy of each raw input.
  localparam int SYNC_STAGES = 2;

  localparam int BOARD_CLOCK_HZ    = 100_000_000;
  localparam int BOARD_DEBOUNCE_MS = 10;

  // 100 MHz * 10 ms = 1,000,000 consecutive stable samples.
  localparam int BOARD_DEBOUNCE_CYCLES = (BOARD_CLOCK_HZ / 1000) * BOARD_DEBOUNCE_MS;

endpackage : board_io_pkg

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//
// Purpose:
//   Conditions one asynchronous switch/button bit. The raw input passes
//   through a SYNC_STAGES-deep synchronizer; a two-state FSM with a counter
//   then requires DEBOUNCE_CYCLES consecutive disagreeing samples before
//   the accepted level flips. Registered rise/fall pulses are produced in
//   the same cycle as the first cycle of the new level.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a change
//                    (must be >= 1)
//
// Ports:
//   clk_i        in   core clock
//   rst_i        in   synchronous active-low reset
//   raw_i        in   asynchronous raw input bit
//   level_o      out  debounced level
//   rise_o       out  one-cycle pulse coincident with level_o going 0->1
//   fall_o       out  one-cycle pulse coincident with level_o going 1->0
//   rise_next_o  out  combinational: rise_o will be high after this edge
//   fall_next_o  out  combinational: fall_o will be high after this edge
// ---------------------------------------------------------------------------
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_next_o,
  output logic fall_next_o
);

  // Wide enough to hold DEBOUNCE_CYCLES; in practice it tops out at
  // DEBOUNCE_CYCLES-1 because the flip happens on that sample.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic [SYNC_STAGES-1:0] sync_chain_d;
  logic                   sync_q;

  db_state_e              state_q;
  db_state_e              state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   level_q;
  logic                   level_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   flip;

  // Shift the raw bit into the synchronizer; the last stage is the only
  // copy the FSM is allowed to look at.
  always_comb begin
    sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], raw_i};
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // Next-state logic. Any agreement between the synchronized input and the
  // accepted level throws away partial progress, so a bounce never
  // accumulates across glitches. With a one-cycle debounce the first
  // disagreeing sample is accepted directly from STABLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;

    case (state_q)
      DB_STABLE: begin
        if (sync_q == level_q) begin
          cnt_d = '0;
        end else if (DEBOUNCE_CYCLES == 1) begin
          flip  = 1'b1;
          cnt_d = '0;
        end else begin
          state_d = DB_PENDING;
          cnt_d   = CNT_ONE;
        end
      end

      DB_PENDING: begin
        if (sync_q == level_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          flip    = 1'b1;
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The pulses are registered on the same edge as the level, so they line
  // up with the first cycle of the new value. Direction comes from the
  // level being left, which also guarantees rise and fall are exclusive.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (flip) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
      fall_d  = level_q;
    end
  end

  // State register. Reset wins over everything, including a change that is
  // half way through being timed.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync_chain_q <= '0;
      state_q      <= DB_STABLE;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
    end else begin
      sync_chain_q <= sync_chain_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
    end
  end

  assign level_o     = level_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;

  // Exposed so the top can register its change flag on the same edge as
  // the pulses instead of one cycle later. Gated by reset so the flag
  // clears together with the pulses.
  assign rise_next_o = rise_d & rst_i;
  assign fall_next_o = fall_d & rst_i;

endmodule : debounce_channel

// File: rtl/board_input_debouncer.sv
// ---------------------------------------------------------------------------
// board_input_debouncer
//
// Purpose:
//   Input-side conditioning for the board switches and push-buttons. Every
//   channel is synchronized into the core clock domain and debounced
//   independently; the block delivers a clean level per channel, one-cycle
//   rise/fall pulses, and a single registered "something changed" flag.
//
// Parameters:
//   WIDTH            number of independent input channels
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a change
//                    (must be >= 1)
//
// Ports:
//   clk_i     in   core clock (only clock)
//   rst_i     in   synchronous active-low reset
//   raw_i     in   [WIDTH] asynchronous switch/button inputs
//   level_o   out  [WIDTH] debounced level per channel
//   rise_o    out  [WIDTH] one-cycle pulse when level_o goes 0->1
//   fall_o    out  [WIDTH] one-cycle pulse when level_o goes 1->0
//   change_o  out  registered OR of all rise/fall pulses, aligned with them
// ---------------------------------------------------------------------------
module board_input_debouncer
  import board_io_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o
);

  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;
  logic             change_q;
  logic             change_d;

  // One identical, fully independent conditioner per input bit.
  for (genvar ch = 0; ch < WIDTH; ch++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .raw_i       (raw_i[ch]),
      .level_o     (level_o[ch]),
      .rise_o      (rise_o[ch]),
      .fall_o      (fall_o[ch]),
      .rise_next_o (rise_next[ch]),
      .fall_next_o (fall_next[ch])
    );
  end

  // Built from the channels' next-pulse values so the registered flag lands
  // in the same cycle as the pulses it summarises.
  always_comb begin
    change_d = |(rise_next | fall_next);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      change_q <= 1'b0;
    end else begin
      change_q <= change_d;
    end
  end

  assign change_o = change_q;

endmodule : board_input_debouncer

// File: tb/tb_board_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_board_input_debouncer
//
// Purpose:
//   Self-checking bench for board_input_debouncer with WIDTH = 8 and
//   DEBOUNCE_CYCLES = 4. A table of {raw, rst, expected outputs} rows covers
//   reset, release, clean falls/presses and bounce rejection; hand-written
//   sequences cover bounce-then-settle, simultaneous channels and reset in
//   the middle of a pending change.
// ---------------------------------------------------------------------------
module tb_board_input_debouncer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [W-1:0] raw_i = '0;
  logic [W-1:0] level_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic         change_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] raw;
    logic         rst;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         change;
  } vec_t;

  vec_t vecs[$];

  board_input_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .raw_i    (raw_i),
    .level_o  (level_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .change_o (change_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic add_row(input logic [W-1:0] raw, input logic rst,
                         input logic [W-1:0] level, input logic [W-1:0] rise,
                         input logic [W-1:0] fall, input logic change);
    vec_t v;
    v.raw    = raw;
    v.rst    = rst;
    v.level  = level;
    v.rise   = rise;
    v.fall   = fall;
    v.change = change;
    vecs.push_back(v);
  endtask

  task automatic add_hold(input logic [W-1:0] raw, input logic rst,
                          input logic [W-1:0] level, input int n);
    for (int i = 0; i < n; i++) begin
      add_row(raw, rst, level, '0, '0, 1'b0);
    end
  endtask

  // Drive inputs, let one rising edge happen, then settle 1 time unit so
  // outputs are sampled away from the edge.
  task automatic apply_stimulus(input logic [W-1:0] raw, input logic rst);
    raw_i = raw;
    rst_i = rst;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string name, input logic [W-1:0] level,
                              input logic [W-1:0] rise, input logic [W-1:0] fall,
                              input logic change);
    checks++;
    if (level_o !== level) begin
      failures++;
      $display("[TB] FAIL %s level_o actual=%h required=%h", name, level_o, level);
    end
    checks++;
    if (rise_o !== rise) begin
      failures++;
      $display("[TB] FAIL %s rise_o actual=%h required=%h", name, rise_o, rise);
    end
    checks++;
    if (fall_o !== fall) begin
      failures++;
      $display("[TB] FAIL %s fall_o actual=%h required=%h", name, fall_o, fall);
    end
    checks++;
    if (change_o !== change) begin
      failures++;
      $display("[TB] FAIL %s change_o actual=%b required=%b", name, change_o, change);
    end
  endtask

  initial begin
    // Reset with all inputs high: everything held at zero.
    add_hold(8'hFF, 1'b0, 8'h00, 3);
    // Release: rise on all channels on the 6th edge with reset high.
    add_hold(8'hFF, 1'b1, 8'h00, 5);
    add_row (8'hFF, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1);
    add_hold(8'hFF, 1'b1, 8'hFF, 2);
    // All inputs released: fall pulses at k+5.
    add_hold(8'h00, 1'b1, 8'hFF, 5);
    add_row (8'h00, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1);
    add_hold(8'h00, 1'b1, 8'h00, 2);
    // Clean press on channel 0.
    add_hold(8'h01, 1'b1, 8'h00, 5);
    add_row (8'h01, 1'b1, 8'h01, 8'h01, 8'h00, 1'b1);
    add_hold(8'h01, 1'b1, 8'h01, 2);
    // Channel 3 high for 3 cycles only: counter reaches D-1 then glitches back.
    add_hold(8'h09, 1'b1, 8'h01, 3);
    add_hold(8'h01, 1'b1, 8'h01, 6);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].raw, vecs[i].rst);
      check_output($sformatf("vec%0d", i), vecs[i].level, vecs[i].rise,
                   vecs[i].fall, vecs[i].change);
    end

    // Bounce then settle on channel 3: high 2, low 1, then high steadily.
    apply_stimulus(8'h09, 1'b1);
    check_output("settle_hi0", 8'h01, 8'h00, 8'h00, 1'b0);
    apply_stimulus(8'h09, 1'b1);
    check_output("settle_hi1", 8'h01, 8'h00, 8'h00, 1'b0);
    apply_stimulus(8'h01, 1'b1);
    check_output("settle_lo", 8'h01, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(8'h09, 1'b1);
      check_output($sformatf("settle%0d", i), (i < 5) ? 8'h01 : 8'h09,
                   (i == 5) ? 8'h08 : 8'h00, 8'h00, (i == 5));
    end

    // Get channel 6 accepted high so it can fall later.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(8'h49, 1'b1);
      check_output($sformatf("ch6_up%0d", i), (i < 5) ? 8'h09 : 8'h49,
                   (i == 5) ? 8'h40 : 8'h00, 8'h00, (i == 5));
    end

    // Channel 1 rises and channel 6 falls on the same edge.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(8'h0B, 1'b1);
      check_output($sformatf("indep%0d", i), (i < 5) ? 8'h49 : 8'h0B,
                   (i == 5) ? 8'h02 : 8'h00, (i == 5) ? 8'h40 : 8'h00, (i == 5));
    end

    // Channel 2 rises; reset arrives after two disagreeing samples.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'h0F, 1'b1);
      check_output($sformatf("pend%0d", i), 8'h0B, 8'h00, 8'h00, 1'b0);
    end
    apply_stimulus(8'h0F, 1'b0);
    check_output("pend_rst", 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(8'h0F, 1'b1);
      check_output($sformatf("post_rst%0d", i), (i < 5) ? 8'h00 : 8'h0F,
                   (i == 5) ? 8'h0F : 8'h00, 8'h00, (i == 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_board_input_debouncer
